// File: rtl/sc_fir_sequencer_if.sv
// Sample-in / result-out valid-ready bundle of the stochastic FIR sequencer.
// master = upstream/downstream environment, slave = sequencer.
interface sc_fir_sequencer_if #(
    parameter int N = 12
);
    logic       in_valid;
    logic       in_ready;
    logic [N:0] in_data;
    logic       res_valid;
    logic       res_ready;
    logic [N:0] res_data;

    modport master (
        output in_valid, output in_data, input in_ready,
        input res_valid, input res_data, output res_ready
    );

    modport slave (
        input in_valid, input in_data, output in_ready,
        output res_valid, output res_data, input res_ready
    );
endinterface

// File: rtl/sc_fir_sequencer.sv
// Feeder/controller for the stochastic FIR accumulator: delay line, window counter, RNG, result capture.
// Define SC_VDC_RNG_EN to replace the LFSR with a bit-reversed (van der Corput) copy of sel_bits.
module sc_fir_sequencer #(
    parameter int           N         = 12,
    parameter int           TAPS      = 39,
    parameter logic [N-1:0] LFSR_SEED = 12'hACE,
    parameter logic [N-1:0] LFSR_TAPS = 12'hE08
) (
    input  logic                  clock,
    input  logic                  reset_n,
    sc_fir_sequencer_if.slave     bus,
    output logic [TAPS*(N+1)-1:0] taps,
    output logic                  hwa_start,
    output logic [N-1:0]          sel_bits,
    output logic [N-1:0]          r_y,
    input  logic [N:0]            hwa_out,
    input  logic                  hwa_done
);
    typedef enum logic [1:0] {IDLE, START, RUN, HOLD} state_t;

    localparam logic [N-1:0] SEL_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] SEL_LAST = {N{1'b1}};

    state_t       state_q;
    logic [N-1:0] sel_q;
    logic         hwa_start_q;
    logic         in_ready_q;
    logic         res_valid_q;
    logic [N:0]   res_data_q;
    logic         accept;
    logic         last_sel;

    assign accept   = bus.in_valid && in_ready_q;
    assign last_sel = (sel_q == SEL_LAST);

    // Delay line: only an accepted sample moves it, so it is frozen for the whole window.
    genvar gi;
    generate
        for (gi = 0; gi < TAPS; gi++) begin : g_tap
            logic [N:0] tap_q;
            if (gi == 0) begin : g_head
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        tap_q <= '0;
                    end else if (accept) begin
                        tap_q <= bus.in_data;
                    end
                end
            end else begin : g_shift
                always_ff @(posedge clock or negedge reset_n) begin
                    if (!reset_n) begin
                        tap_q <= '0;
                    end else if (accept) begin
                        tap_q <= g_tap[gi-1].tap_q;
                    end
                end
            end
            assign taps[gi*(N+1) +: (N+1)] = tap_q;
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            hwa_start_q <= 1'b0;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= START;
                        in_ready_q  <= 1'b0;
                        hwa_start_q <= 1'b1;
                        sel_q       <= '0;
                    end
                end
                START: begin
                    state_q     <= RUN;
                    hwa_start_q <= 1'b0;
                end
                RUN: begin
                    // The counter alone ends the window; hwa_done is only cross-checked.
                    sel_q <= sel_q + SEL_ONE;
                    if (last_sel) begin
                        res_data_q  <= hwa_out;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SC_VDC_RNG_EN
    logic [N-1:0] sel_rev;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rev
            assign sel_rev[gi] = sel_q[N-1-gi];
        end
    endgenerate
    assign r_y = (state_q == RUN) ? sel_rev : '0;
`else
    logic [N-1:0] lfsr_q;
    logic [N-1:0] lfsr_d;

    assign lfsr_d = {lfsr_q[N-2:0], ^(lfsr_q & LFSR_TAPS)};

    // Reloaded in START so every window sees the same sequence starting at the seed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (state_q == START) begin
            lfsr_q <= LFSR_SEED;
        end else if (state_q == RUN) begin
            lfsr_q <= lfsr_d;
        end
    end
    assign r_y = lfsr_q;
`endif

    assign sel_bits      = sel_q;
    assign hwa_start     = hwa_start_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

    a_hwa_done_consistent: assert property (@(posedge clock) disable iff (!reset_n)
        hwa_done == ((state_q == RUN) && last_sel));
endmodule
